// File: rtl/cmp_seq_ctrl.sv
// Sequential wide-operand magnitude comparator: walks 3-bit slices MSB-first,
// one per clock, and stops at the first unequal slice.
module cmp_seq_ctrl #(
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3*SLICES-1:0]   a,
  input  logic [3*SLICES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            y
);

  localparam int W    = 3 * SLICES;
  localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(SLICES - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = '0;
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [2:0] Y_NONE = 3'b000;
  localparam logic [2:0] Y_EQ   = 3'b001;
  localparam logic [2:0] Y_GT   = 3'b010;
  localparam logic [2:0] Y_LT   = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [IDXW-1:0]   idx_r;
  logic [2:0]        slice_a_s;
  logic [2:0]        slice_b_s;
  logic [2:0]        slice_res_s;
  logic              last_slice_s;
  logic              capture_s;
  logic              resolve_s;
  logic [IDXW-1:0]   idx_next_s;
  logic              busy_next_s;
  logic              done_next_s;
  logic [2:0]        y_next_s;

  // Selects the 3-bit slice at index i; out-of-range indices read as zero.
  function automatic logic [2:0] slice_at(input logic [W-1:0] v,
                                          input logic [IDXW-1:0] i);
    logic [2:0] s;
    s = 3'b000;
    for (int k = 0; k < SLICES; k++) begin
      if (i == IDXW'(k)) begin
        s = v[3*k +: 3];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Same {lt, gt, eq} one-hot encoding as the existing 3-bit comparator.
  function automatic logic [2:0] cmp3(input logic [2:0] sa, input logic [2:0] sb);
    logic [2:0] r;
    if (sa > sb) begin
      r = Y_GT;
    end else if (sa < sb) begin
      r = Y_LT;
    end else begin
      r = Y_EQ;
    end
    return r;
  endfunction

  // Slice comparison of the frozen operands at the current index.
  always_comb begin
    slice_a_s    = slice_at(a_q, idx_r);
    slice_b_s    = slice_at(b_q, idx_r);
    slice_res_s  = cmp3(slice_a_s, slice_b_s);
    last_slice_s = (idx_r == IDX_ZERO);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: a CMP pass ends on an unequal slice or on slice 0.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CMP;
        end else begin
          next_state_s = IDLE;
        end
      end
      CMP: begin
        if ((slice_res_s != Y_EQ) || last_slice_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CMP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output/datapath decode: next values for the registered outputs and index.
  always_comb begin
    capture_s   = 1'b0;
    resolve_s   = 1'b0;
    idx_next_s  = idx_r;
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    y_next_s    = y;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s   = 1'b1;
          idx_next_s  = IDX_TOP;
          busy_next_s = 1'b1;
        end else begin
          busy_next_s = 1'b0;
        end
      end
      CMP: begin
        if ((slice_res_s != Y_EQ) || last_slice_s) begin
          resolve_s   = 1'b1;
          done_next_s = 1'b1;
          busy_next_s = 1'b0;
          y_next_s    = slice_res_s;
        end else begin
          idx_next_s  = idx_r - IDX_ONE;
          busy_next_s = 1'b1;
        end
      end
      default: begin
        busy_next_s = 1'b0;
        y_next_s    = Y_NONE;
      end
    endcase
  end

  // Operand capture and slice index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_r <= IDX_ZERO;
    end else begin
      if (capture_s) begin
        a_q <= a;
        b_q <= b;
      end else begin
        a_q <= a_q;
        b_q <= b_q;
      end
      idx_r <= idx_next_s;
    end
  end

  // Registered outputs; y only moves on a resolving cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      y    <= Y_NONE;
    end else begin
      busy <= busy_next_s;
      done <= done_next_s;
      if (resolve_s) begin
        y <= y_next_s;
      end else begin
        y <= y;
      end
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: directed scenarios plus randomized
// traffic against a whole-operand reference model.
module tb_cmp_seq_ctrl;

  localparam int SLICES = 4;
  localparam int W      = 3 * SLICES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2:0]    y;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [2:0]    m_y    = 3'b000;
  logic [2:0]    m_res  = 3'b000;
  int            m_cnt  = 0;

  cmp_seq_ctrl #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycles to resolve = number of slices examined down to the first difference.
  function automatic int latency(input logic [W-1:0] x, input logic [W-1:0] z);
    for (int s = SLICES - 1; s >= 0; s--) begin
      if (x[3*s +: 3] != z[3*s +: 3]) return SLICES - s;
    end
    return SLICES;
  endfunction

  function automatic logic [2:0] result(input logic [W-1:0] x, input logic [W-1:0] z);
    if (x > z) return 3'b010;
    if (x < z) return 3'b100;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_y    = 3'b000;
    m_cnt  = 0;
  endtask

  // One rising edge of the reference, using pre-edge inputs and state.
  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_y    = m_res;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_cnt  = latency(a, b);
      m_res  = result(a, b);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, m_busy});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
    chk({tag, "_y"},    {29'd0, y},    {29'd0, m_y});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] z, input string tag);
    a = x;
    b = z;
    start = 1'b1;
    step({tag, "_e0"});
    start = 1'b0;
    for (int i = 0; i < latency(x, z); i++) step(tag);
  endtask

  initial begin
    // Reset with start held high
    rst_n = 1'b0;
    start = 1'b1;
    a = 12'hFFF;
    b = 12'h000;
    #12;
    model_reset();
    check_outs("rst");
    chk("rst_y_const", {29'd0, y}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("rst_idle");

    // Equal operands: done after four slices
    run_op(12'hABC, 12'hABC, "eq");
    chk("eq_y_const", {29'd0, y}, 32'd1);
    chk("eq_done_const", {31'd0, done}, 32'd1);
    step("eq_after");
    chk("eq_done_drop", {31'd0, done}, 32'd0);

    // Early exit on the top slice
    a = 12'h800; b = 12'h7FF; start = 1'b1;
    step("early_e0");
    start = 1'b0;
    step("early_e1");
    chk("early_y_const", {29'd0, y}, 32'd2);
    chk("early_busy_const", {31'd0, busy}, 32'd0);

    // Last-slice difference with ignored operand change and start while busy
    a = 12'h123; b = 12'h124; start = 1'b1;
    step("last_e0");
    start = 1'b0;
    step("last_e1");
    a = 12'hFFF; start = 1'b1;
    step("last_e2");
    start = 1'b0;
    step("last_e3");
    step("last_e4");
    chk("last_y_const", {29'd0, y}, 32'd4);
    chk("last_done_const", {31'd0, done}, 32'd1);
    step("last_after");

    // Back-to-back: second request presented during the done cycle
    a = 12'h400; b = 12'h200; start = 1'b1;
    step("b2b_e0");
    step("b2b_e1");
    chk("b2b_y1_const", {29'd0, y}, 32'd2);
    a = 12'h001; b = 12'h002;
    step("b2b_acc");
    chk("b2b_busy2_const", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step("b2b_op2");
    chk("b2b_y2_const", {29'd0, y}, 32'd4);
    chk("b2b_done2_const", {31'd0, done}, 32'd1);
    step("b2b_after");

    // Asynchronous reset in the middle of a comparison
    a = 12'h555; b = 12'h555; start = 1'b1;
    step("mid_e0");
    start = 1'b0;
    step("mid_e1");
    step("mid_e2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("mid_rst");
    #1 rst_n = 1'b1;
    step("mid_rel");
    run_op(12'h555, 12'h555, "mid_again");
    chk("mid_again_y_const", {29'd0, y}, 32'd1);

    // Randomized traffic; b often shares most slices with a to stretch latency
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int sel;
      int sl;
      ra  = W'($urandom);
      sel = int'($urandom_range(0, 3));
      sl  = int'($urandom_range(0, SLICES - 1));
      rb  = ra;
      if (sel == 0) rb = W'($urandom);
      else if (sel == 1) rb[3*sl +: 3] = 3'($urandom);
      a = ra;
      b = rb;
      start = ($urandom_range(0, 2) != 0);
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("rnd_rst");
        #1 rst_n = 1'b1;
      end
      step("rnd");
    end
    start = 1'b0;
    for (int i = 0; i < SLICES + 1; i++) step("rnd_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
